// File: rtl/key_scan4x4.sv
// ---------------------------------------------------------------------------
// key_scan4x4
//   Scans a 4x4 active-low matrix keypad one row at a time. It debounces
//   whole scan frames (four row dwells) and reports accepted keys as a
//   4-bit code with a one-clock valid strobe. The last key is also shown on
//   a seven-segment digit.
//
// Parameters
//   SCAN_DIV       clocks per row dwell (>= 4)
//   DEB_CNT        consecutive identical frames to accept a press/release (1..15)
//   REPEAT_FRAMES  frames between auto-repeat strobes (KEY_REPEAT_EN only)
//
// Optional feature macro
//   KEY_REPEAT_EN  when defined, a held key re-strobes key_valid every
//                  REPEAT_FRAMES frames; when undefined, one strobe per press.
//
// Ports
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   col[3:0]   keypad columns, active low, externally pulled up (asynchronous)
//   row[3:0]   row drive, active-low one-hot
//   key_code   last accepted key, 4*row_index + col_index
//   key_valid  one-clock strobe per accepted key event
//   key_down   high while the accepted key is held
//   seg7[6:0]  active-low segments {g..a} showing key_code in hex
// ---------------------------------------------------------------------------
module key_scan4x4 #(
    parameter int SCAN_DIV      = 4096,
    parameter int DEB_CNT       = 4
`ifdef KEY_REPEAT_EN
   ,parameter int REPEAT_FRAMES = 64
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] col,
    output logic [3:0] row,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_down,
    output logic [6:0] seg7
);

    typedef enum logic [1:0] {IDLE, PRESS_CHK, HELD, RELEASE_CHK} state_t;
    typedef enum logic [1:0] {FR_NONE, FR_KEY, FR_MULTI} frame_t;

    localparam int              DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [3:0]      DEB      = 4'(DEB_CNT);

    // ------------------------------------------------------------------
    // Column synchronizer. Idle level is all-ones (pull-ups).
    // ------------------------------------------------------------------
    logic [3:0] col_s1, col_s2;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_s1 <= 4'hF;
            col_s2 <= 4'hF;
        end else begin
            col_s1 <= col;
            col_s2 <= col_s1;
        end
    end

    // ------------------------------------------------------------------
    // Row dwell prescaler and row index
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] div_q;
    logic [1:0]       r_q;
    logic             tick;
    logic             frame_end;

    assign tick      = (div_q == DIV_LAST);
    assign frame_end = tick && (r_q == 2'd3);
    assign row       = ~(4'b0001 << r_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
            r_q   <= 2'd0;
        end else begin
            if (tick) begin
                div_q <= '0;
                r_q   <= r_q + 2'd1;
            end else begin
                div_q <= div_q + DIV_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Hit detection for the current row and frame accumulation.
    // Hit counts saturate at 2: anything beyond one hit is MULTI.
    // ------------------------------------------------------------------
    logic [1:0] row_hits;
    logic [1:0] row_col;

    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would infer a latch.
    always_comb begin
        row_hits = 2'd0;
        row_col  = 2'd0;
        for (int c = 0; c < 4; c++) begin
            if (!col_s2[c]) begin
                if (row_hits != 2'd2) row_hits = row_hits + 2'd1;
                row_col = 2'(c);
            end
        end
    end

    logic [1:0] acc_hits;
    logic [3:0] acc_code;
    logic [2:0] hit_sum;
    logic [1:0] frame_hits;
    logic [3:0] frame_code;
    frame_t     frame_res;

    // Running result including the row sampled on this tick.
    assign hit_sum    = {1'b0, acc_hits} + {1'b0, row_hits};
    assign frame_hits = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
    assign frame_code = (acc_hits != 2'd0) ? acc_code : {r_q, row_col};

    always_comb begin
        case (frame_hits)
            2'd0:    frame_res = FR_NONE;
            2'd1:    frame_res = FR_KEY;
            default: frame_res = FR_MULTI;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_hits <= 2'd0;
            acc_code <= 4'd0;
        end else if (tick) begin
            if (r_q == 2'd3) begin
                acc_hits <= 2'd0;
                acc_code <= 4'd0;
            end else begin
                acc_hits <= frame_hits;
                acc_code <= frame_code;
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame-level debounce FSM
    // ------------------------------------------------------------------
    state_t     state_q, state_n;
    logic [3:0] cand_q, cand_n;
    logic [3:0] cnt_q, cnt_n;
    logic [3:0] code_n;
    logic       valid_n;
    logic       shown_q, shown_n;
    logic [3:0] cnt_sat;
    logic       is_cand;

    assign cnt_sat = (cnt_q >= DEB) ? DEB : cnt_q + 4'd1;
    assign is_cand = (frame_res == FR_KEY) && (frame_code == cand_q);

`ifdef KEY_REPEAT_EN
    localparam int             REP_W    = $clog2(REPEAT_FRAMES + 1);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_FRAMES);
    logic [REP_W-1:0] rep_q, rep_n, rep_inc;
    assign rep_inc = rep_q + REP_W'(1);
`endif

    always_comb begin
        state_n = state_q;
        cand_n  = cand_q;
        cnt_n   = cnt_q;
        code_n  = key_code;
        valid_n = 1'b0;
        shown_n = shown_q;
`ifdef KEY_REPEAT_EN
        rep_n   = rep_q;
`endif
        if (frame_end) begin
            case (state_q)
                IDLE: begin
                    if (frame_res == FR_KEY) begin
                        cand_n = frame_code;
                        cnt_n  = 4'd1;
                        if (DEB == 4'd1) begin
                            state_n = HELD;
                            code_n  = frame_code;
                            valid_n = 1'b1;
                            shown_n = 1'b1;
                        end else begin
                            state_n = PRESS_CHK;
                        end
                    end
                end
                PRESS_CHK: begin
                    if (is_cand) begin
                        cnt_n = cnt_sat;
                        if (cnt_sat == DEB) begin
                            state_n = HELD;
                            code_n  = cand_q;
                            valid_n = 1'b1;
                            shown_n = 1'b1;
                        end
                    end else if (frame_res == FR_KEY) begin
                        cand_n = frame_code;
                        cnt_n  = 4'd1;
                    end else begin
                        state_n = IDLE;
                        cnt_n   = 4'd0;
                    end
                end
                HELD: begin
                    if (is_cand) begin
`ifdef KEY_REPEAT_EN
                        if (rep_inc == REP_LAST) begin
                            valid_n = 1'b1;
                            rep_n   = '0;
                        end else begin
                            rep_n   = rep_inc;
                        end
`endif
                    end else begin
                        // A different key or MULTI counts as a release frame.
                        cnt_n   = 4'd1;
                        state_n = (DEB == 4'd1) ? IDLE : RELEASE_CHK;
                    end
                end
                RELEASE_CHK: begin
                    if (is_cand) begin
                        state_n = HELD;
                    end else begin
                        cnt_n = cnt_sat;
                        if (cnt_sat == DEB) state_n = IDLE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
`ifdef KEY_REPEAT_EN
        if (state_n != HELD) rep_n = '0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cand_q    <= 4'd0;
            cnt_q     <= 4'd0;
            key_code  <= 4'd0;
            key_valid <= 1'b0;
            key_down  <= 1'b0;
            shown_q   <= 1'b0;
`ifdef KEY_REPEAT_EN
            rep_q     <= '0;
`endif
        end else begin
            state_q   <= state_n;
            cand_q    <= cand_n;
            cnt_q     <= cnt_n;
            key_code  <= code_n;
            key_valid <= valid_n;
            key_down  <= (state_n == HELD) || (state_n == RELEASE_CHK);
            shown_q   <= shown_n;
`ifdef KEY_REPEAT_EN
            rep_q     <= rep_n;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Seven-segment display, registered one clock behind key_code.
    // ------------------------------------------------------------------
    function automatic logic [6:0] hex_font(input logic [3:0] v);
        case (v)
            4'h0: hex_font = 7'h3F;
            4'h1: hex_font = 7'h06;
            4'h2: hex_font = 7'h5B;
            4'h3: hex_font = 7'h4F;
            4'h4: hex_font = 7'h66;
            4'h5: hex_font = 7'h6D;
            4'h6: hex_font = 7'h7D;
            4'h7: hex_font = 7'h07;
            4'h8: hex_font = 7'h7F;
            4'h9: hex_font = 7'h6F;
            4'hA: hex_font = 7'h77;
            4'hB: hex_font = 7'h7C;
            4'hC: hex_font = 7'h39;
            4'hD: hex_font = 7'h5E;
            4'hE: hex_font = 7'h79;
            default: hex_font = 7'h71;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg7 <= 7'h7F;
        end else begin
            seg7 <= shown_q ? ~hex_font(key_code) : 7'h7F;
        end
    end

endmodule

// File: doc/key_scan4x4.md
# key_scan4x4

Scans a 4x4 active-low matrix keypad, debounces at whole-frame granularity, and emits a 4-bit key code with a one-clock valid strobe. It is the input-side counterpart to the LED pattern and seven-segment output logic: it produces the key events that select pattern and speed, and it shows the last key on a seven-segment digit. Single clock domain; the keypad columns are asynchronous inputs.

## Interface
- SCAN_DIV, 4096: clocks per row dwell; legal values are 4 or more.
- DEB_CNT, 4: consecutive identical frames required to accept a press or a release; legal values are 1 to 15.
- REPEAT_FRAMES, 64: frames between auto-repeat strobes; used only when KEY_REPEAT_EN is defined.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- col  in  4  keypad columns, active low, externally pulled up.
- row  out  4  row drive, active-low one-hot.
- key_code  out  4  last accepted key, code = 4*row_index + col_index.
- key_valid  out  1  one-clock strobe for an accepted key event.
- key_down  out  1  high while the accepted key is held.
- seg7  out  7  active-low segments {g..a} showing hex key_code.

## Operation
- `col` passes through a 2-flop synchronizer before any use.
- Prescaler counts 0 to SCAN_DIV-1. `tick` is asserted when the count equals SCAN_DIV-1.
- Row index r cycles 0→1→2→3→0, advancing on `tick`. `row = ~(4'b1 << r)`.
- On `tick`, before r advances, the synchronized `col` is sampled for row r. Any low bit c is a hit (r,c).
- A frame is 4 dwells, ending on the `tick` of r=3. The frame result is one of:
  - NONE: no hits.
  - KEY(code): exactly one hit.
  - MULTI: two or more hits, whether in the same row or in different rows.
- Debounce FSM advances only at frame end.
  - IDLE: KEY(k) loads cand=k and cnt=1, then goes to PRESS_CHK. With DEB_CNT=1 it goes straight to HELD.
  - PRESS_CHK: KEY(cand) increments cnt. When cnt reaches DEB_CNT: go to HELD, load key_code=cand, pulse key_valid. KEY(other) reloads cand and sets cnt=1. NONE or MULTI returns to IDLE.
  - HELD: key_down=1. NONE loads cnt=1 and goes to RELEASE_CHK. KEY(cand) stays in HELD. KEY(other) or MULTI is treated as NONE.
  - RELEASE_CHK: NONE increments cnt. When cnt reaches DEB_CNT, key_down=0 and the FSM goes to IDLE. KEY(cand) returns to HELD with no new strobe.
- key_code holds its value after release.
- seg7 is the hex font of key_code (0–9, A, b, C, d, E, F), inverted. seg7 is blank (7'h7F) until the first accepted key.

## Timing
- Reset values: row=4'b1110, key_code=0, key_valid=0, key_down=0, seg7=7'h7F, FSM=IDLE, prescaler=0.
- Frame period is 4*SCAN_DIV clocks.
- The `col` sample reflects the pad level 2 clocks before `tick`.
- Press latency: key_valid is high in the clock after the frame-end `tick` of the DEB_CNT-th consecutive KEY(k) frame. key_code and key_down update in that same clock. seg7 updates one clock later (registered).
- Release latency: key_down falls in the clock after the frame-end `tick` of the DEB_CNT-th consecutive NONE frame.
- A reset mid-scan or mid-debounce aborts immediately. No key_valid is emitted during or after reset until a full qualification completes.
- Prescaler and row counter wrap silently. The cnt register saturates at DEB_CNT.

## Configuration
- KEY_REPEAT_EN defined:
  - In HELD, a frame counter starts at 0 on entry to HELD and increments on each KEY(cand) frame.
  - When the counter reaches REPEAT_FRAMES, key_valid pulses (same code) and the counter clears.
  - Leaving HELD clears the counter.
- KEY_REPEAT_EN undefined: exactly one key_valid per press. No repeat counter logic is present.

## Test plan
- Use SCAN_DIV=4 and DEB_CNT=3 (16-clock frames). Hold col=4'b1101 only while row=4'b1011, i.e. key (2,1). Expected: key_valid pulses once, key_code=9, seg7=~7'h6F. Total valid pulses = 1.
- Add 1–2-frame bounces before the stable hold; each bounce alternates NONE with KEY(9). Expected: no key_valid until 3 clean KEY(9) frames, then a single pulse.
- Hold keys (0,0) and (1,3) together. Expected: MULTI every frame, no key_valid, key_down=0. Then release (1,3). Expected: key_valid with key_code=0 after 3 frames.
- Press key 5 to HELD, release for 2 frames, press again, then release for 3 frames. Expected: key_down stays 1 through the 2-frame gap with no second strobe, then falls after the 3rd NONE frame. key_code stays 5.
- Assert rst_n=0 in PRESS_CHK after 2 qualifying frames, then release reset with the key still held. Expected: outputs return to reset values, and key_valid occurs exactly 3 frames after reset release.
- With KEY_REPEAT_EN defined and REPEAT_FRAMES=2, hold key F for 8 frames after acceptance. Expected: 1 initial strobe plus 4 repeat strobes, all with key_code=15.
